// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type bit indices and bus layouts for the memory-access stage.
package mem_stage_pkg;

  localparam int DATA_W          = 32;
  localparam int ES_TO_MS_BUS_WD = 83;
  localparam int MS_TO_WS_BUS_WD = 73;
  localparam int STALL_BUS_WD    = 9;
  localparam int FORWARD_BUS_WD  = 33;

  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;
  localparam int LD_LWL = 5;
  localparam int LD_LWR = 6;

  typedef struct packed {
    logic              res_from_mem;
    logic [6:0]        inst_load;
    logic [4:0]        ld_extd_op;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic [3:0]        rf_strb;
    logic [4:0]        dest;
    logic [DATA_W-1:0] final_result;
    logic [DATA_W-1:0] pc;
  } ws_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// Execute -> memory -> write-back handshake, result buses and SRAM read data.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [STALL_BUS_WD-1:0]    stall_ms_bus;
  logic [FORWARD_BUS_WD-1:0]  forward_ms_bus;
  logic [DATA_W-1:0]          data_sram_rdata;

  modport master (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, stall_ms_bus, forward_ms_bus
  );

  modport slave (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, stall_ms_bus, forward_ms_bus
  );
endinterface

// File: rtl/mem_stage_ld_select.sv
// Combinational load-data extraction: byte/half/word extension and LWL/LWR merge strobes.
module mem_stage_ld_select
  import mem_stage_pkg::*;
(
  input  logic [6:0]        inst_load,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ld_value,
  output logic [3:0]        ld_strb
);

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] v);
    logic signed [DATA_W-1:0] w;
    w = v;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] v);
    logic signed [DATA_W-1:0] w;
    w = v;
    return w;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_data[{a, 3'b000} +: 8];
    half_sel = a[1] ? mem_data[31:16] : mem_data[15:0];
    ld_value = mem_data;
    ld_strb  = 4'b1111;
    if (inst_load[LD_LB]) begin
      ld_value = sext8(byte_sel);
    end else if (inst_load[LD_LBU]) begin
      ld_value = {24'd0, byte_sel};
    end else if (inst_load[LD_LH]) begin
      ld_value = sext16(half_sel);
    end else if (inst_load[LD_LHU]) begin
      ld_value = {16'd0, half_sel};
    end else if (inst_load[LD_LWL]) begin
      // Shift by 3-a bytes; ~a equals 3-a for a 2-bit address.
      ld_value = mem_data << {~a, 3'b000};
      ld_strb  = 4'b1111 << ~a;
    end else if (inst_load[LD_LWR]) begin
      ld_value = mem_data >> {a, 3'b000};
      ld_strb  = 4'b1111 >> a;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the execute result, captures SRAM load data
// across write-back stalls and produces write-back, stall and forward buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mem_stage_if.master   ms
);

  logic              vld_p1;
  es_bus_t           ms_bus_p1;
  logic              rdata_held_p1;
  logic [DATA_W-1:0] held_rdata_p1;

  logic              ms_allowin;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] ld_value;
  logic [3:0]        ld_strb;
  logic [3:0]        rf_strb;
  logic [DATA_W-1:0] final_result;
  logic [4:0]        unused_ld_extd;

  assign ms_allowin     = !vld_p1 || ms.ws_allowin;
  assign unused_ld_extd = ms_bus_p1.ld_extd_op;

  // Execute -> memory boundary; SRAM data is captured here when write-back stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      ms_bus_p1     <= '0;
      rdata_held_p1 <= 1'b0;
      held_rdata_p1 <= '0;
    end else begin
      if (ms_allowin) begin
        vld_p1 <= ms.es_to_ms_valid;
      end
      if (ms.es_to_ms_valid && ms_allowin) begin
        ms_bus_p1 <= es_bus_t'(ms.es_to_ms_bus);
      end
      if (ms_allowin) begin
        rdata_held_p1 <= 1'b0;
      end else if (ms_bus_p1.res_from_mem && !rdata_held_p1) begin
        held_rdata_p1 <= ms.data_sram_rdata;
        rdata_held_p1 <= 1'b1;
      end
    end
  end

  assign mem_data = rdata_held_p1 ? held_rdata_p1 : ms.data_sram_rdata;

  mem_stage_ld_select u_ld_select (
    .inst_load (ms_bus_p1.inst_load),
    .a         (ms_bus_p1.alu_result[1:0]),
    .mem_data  (mem_data),
    .ld_value  (ld_value),
    .ld_strb   (ld_strb)
  );

  always_comb begin
    final_result = ms_bus_p1.alu_result;
    rf_strb      = {4{ms_bus_p1.gr_we}};
    if (ms_bus_p1.res_from_mem) begin
      final_result = ld_value;
      rf_strb      = ms_bus_p1.gr_we ? ld_strb : 4'b0000;
    end
  end

  assign ms.ms_allowin     = ms_allowin;
  assign ms.ms_to_ws_valid = vld_p1;
  assign ms.ms_to_ws_bus   = {rf_strb, ms_bus_p1.dest, final_result, ms_bus_p1.pc};
  assign ms.stall_ms_bus   = {{4{vld_p1 & ms_bus_p1.gr_we}} & rf_strb, ms_bus_p1.dest};
  assign ms.forward_ms_bus = {vld_p1, final_result};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage located directly downstream of the execute stage and upstream of write-back.
- Takes the execute-stage bus. For loads, it captures the synchronous data-SRAM read data, which returns one cycle after the execute stage issues the address.
- Extracts and extends the load data, including partial-word LWL/LWR merging via per-byte register write strobes.
- Forwards results to write-back and sends stall/forward information back to decode.

Parameters:
- ES_TO_MS_BUS_WD, 83, input bus width, taken from the shared header.
- MS_TO_WS_BUS_WD, 73, output bus width.
- STALL_BUS_WD, 9, stall bus width: {4-bit byte write strobe, 5-bit dest}.
- FORWARD_BUS_WD, 33, forward bus width: {valid, 32-bit result}.

Ports:
- clk  in  1  Sole clock. All state updates on its rising edge.
- reset  in  1  Asynchronous, active-high reset.
- ws_allowin  in  1  Write-back stage can accept this cycle.
- ms_allowin  out  1  This stage can accept from execute.
- es_to_ms_valid  in  1  Execute presents a valid instruction.
- es_to_ms_bus  in  83  {res_from_mem[82], inst_load[81:75], ld_extd_op[74:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- ms_to_ws_valid  out  1  Valid instruction offered to write-back.
- ms_to_ws_bus  out  73  {rf_strb[72:69], dest[68:64], final_result[63:32], pc[31:0]}.
- stall_ms_bus  out  9  {{4{ms_valid&gr_we}} & rf_strb, dest}.
- forward_ms_bus  out  33  {ms_valid, final_result}.
- data_sram_rdata  in  32  Read data, valid in the cycle after the address was presented by execute.

Behaviour:
- Reset (async assert): ms_valid=0, bus register=0, rdata_held=0, held_rdata=0.
  - Resulting outputs: ms_to_ws_valid=0, forward valid bit=0, stall_ms_bus strobe=0, ms_allowin=1.
  - Reset mid-instruction discards the instruction and any held read data.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- Latching: on posedge with ms_allowin, ms_valid <= es_to_ms_valid. The bus register loads only when es_to_ms_valid && ms_allowin.
- Read-data capture:
  - In the first cycle of a valid load (!rdata_held), if ws_allowin=0, held_rdata <= data_sram_rdata and rdata_held <= 1.
  - rdata_held clears when the instruction leaves (ms_valid && ws_allowin) or is replaced.
  - Effective data: mem_data = rdata_held ? held_rdata : data_sram_rdata. Each load's data must survive an arbitrary-length stall.
- inst_load one-hot: bit0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 lwl, 6 lwr. ld_extd_op is carried but unused here.
- Address: a = alu_result[1:0].
- Load extraction:
  - lb/lbu: byte a, sign- or zero-extended.
  - lh/lhu: halfword a[1], sign- or zero-extended.
  - lw: word.
  - All of the above use rf_strb=1111.
  - lwl: result = mem_data << (8*(3-a)); rf_strb = a0:1000, a1:1100, a2:1110, a3:1111.
  - lwr: result = mem_data >> (8*a); rf_strb = a0:1111, a1:0111, a2:0011, a3:0001.
- Non-load (res_from_mem=0): final_result = alu_result, rf_strb = {4{gr_we}}.
- Load with gr_we=0: rf_strb=0000.
- Misaligned lh/lw addresses are not checked here; the data is used as if aligned.
- Simultaneous events: ms_valid, ws_allowin and es_to_ms_valid all 1 → the old instruction is handed off and the new one is loaded in the same edge; rdata_held=0 for the new instruction.

Decomposition:
- Shared header `mycpu.h` holds the bus-width macros and the inst_load bit-index constants.
- One natural sub-module: ld_select, purely combinational.
  - Inputs: inst_load, a, mem_data.
  - Outputs: final load value, rf_strb.

Test Plan:
- lw, addr 0x100, rdata 0xDEADBEEF, ws_allowin=1 → next-cycle bus result 0xDEADBEEF, strb 1111, ms_to_ws_valid=1 for 1 cycle.
- lb at a=3, rdata 0x80FF_0000 → result 0xFFFFFF80. lbu same → 0x00000080. lh a=2 → 0xFFFF80FF.
- lwl a=1, rdata 0x11223344 → result 0x33440000, strb 1100. lwr a=2 → result 0x00001122, strb 0011.
- lw stalled 3 cycles (ws_allowin=0) with rdata changing to 0x0 after the first cycle → result stays 0xCAFEF00D throughout; ms_allowin=0; hands off when ws_allowin=1.
- Back-to-back add (alu_result 5, dest 3) then lw: forward_ms_bus={1,5}, stall_ms_bus={1111,3}, then load values follow. gr_we=0 store → strobe 0000.
- Assert reset while a stalled load is held → ms_to_ws_valid=0 immediately (async), and a new load after release sees fresh rdata.
